// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the five-stage LoongArch pipeline. Generates the
// fetch PC, issues requests on a req / addr_ok / data_ok instruction SRAM port
// (at most one outstanding request), buffers one returned instruction and
// hands it to ID through a valid / allow-in handshake. A taken branch from ID
// redirects fetch and squashes any wrong-path instruction or request in flight.
//
// Parameters
//   RESET_PC            first fetch address after reset
//
// Ports
//   clk                 clock
//   reset               synchronous, active-high reset
//   ID_Allow_in         ID can accept an instruction this cycle
//   br_bus[33:0]        {br_taken, br_target[31:0], stall}; stall is unused,
//                       ID back-pressure arrives only through ID_Allow_in
//   IF_to_ID_Valid      IF_to_ID_Bus carries a valid instruction
//   IF_to_ID_Bus[63:0]  {pc, inst}; all zero when not valid
//   inst_sram_req       fetch request
//   inst_sram_addr      fetch address (fetch_pc)
//   inst_sram_addr_ok   request accepted this cycle
//   inst_sram_data_ok   read data returned this cycle
//   inst_sram_rdata     returned instruction word
//   IF_adef             fetch address error (only when IF_ADEF_EN is defined)
//
// Build option
//   IF_ADEF_EN  undefined: inst_sram_addr[1:0] is forced to 2'b00 and IF_adef
//               does not exist.
//               defined: a misaligned fetch_pc issues no request; instead an
//               instruction word of zero is presented to ID with IF_adef=1.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_Allow_in,
  input  logic [33:0] br_bus,
  output logic        IF_to_ID_Valid,
  output logic [63:0] IF_to_ID_Bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_ADEF_EN
  ,
  output logic        IF_adef
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,   // presenting a request to the SRAM
    S_WAIT = 2'd1,   // request accepted, waiting for data_ok
    S_HOLD = 2'd2    // instruction buffered, offered to ID
  } state_t;

  state_t      state_reg,    state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        cancel_reg,   cancel_next;
  logic [31:0] buf_pc_reg,   buf_pc_next;
  logic [31:0] buf_inst_reg, buf_inst_next;
`ifdef IF_ADEF_EN
  logic        adef_reg,     adef_next;
`endif

  logic        req_int;
  logic        hold_active;
  logic [63:0] buf_bus;
  logic [31:0] addr_src;

  // Branch bus fields. The stall bit carries no meaning for this stage.
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_stall_unused;

  assign br_taken        = br_bus[33];
  assign br_target       = br_bus[32:1];
  assign br_stall_unused = br_bus[0];

`ifdef IF_ADEF_EN
  logic fetch_misaligned;
  assign fetch_misaligned = (fetch_pc_reg[1:0] != 2'b00);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_REQ;
      fetch_pc_reg <= RESET_PC;
      cancel_reg   <= 1'b0;
      buf_pc_reg   <= 32'h0;
      buf_inst_reg <= 32'h0;
`ifdef IF_ADEF_EN
      adef_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      cancel_reg   <= cancel_next;
      buf_pc_reg   <= buf_pc_next;
      buf_inst_reg <= buf_inst_next;
`ifdef IF_ADEF_EN
      adef_reg     <= adef_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //
  // A taken branch always reloads fetch_pc on the next edge; the target is
  // never forwarded combinationally onto the SRAM address. data_ok is only
  // meaningful in S_WAIT and is ignored elsewhere.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    cancel_next   = cancel_reg;
    buf_pc_next   = buf_pc_reg;
    buf_inst_next = buf_inst_reg;
`ifdef IF_ADEF_EN
    adef_next     = adef_reg;
`endif
    req_int       = 1'b0;

    case (state_reg)
      S_REQ: begin
`ifdef IF_ADEF_EN
        if (fetch_misaligned) begin
          // No SRAM access for a misaligned PC; the fault itself is handed to
          // ID as a zero instruction. A branch still takes priority.
          if (br_taken) begin
            fetch_pc_next = br_target;
          end else begin
            state_next    = S_HOLD;
            buf_pc_next   = fetch_pc_reg;
            buf_inst_next = 32'h0;
            adef_next     = 1'b1;
          end
        end else
`endif
        begin
          req_int = 1'b1;
          if (br_taken) begin
            fetch_pc_next = br_target;
          end
          if (inst_sram_addr_ok) begin
            state_next = S_WAIT;
            // The accepted request was for the old PC: its data is wrong-path.
            if (br_taken) begin
              cancel_next = 1'b1;
            end
          end
        end
      end

      S_WAIT: begin
        if (br_taken) begin
          fetch_pc_next = br_target;
        end
        if (inst_sram_data_ok) begin
          if (cancel_reg || br_taken) begin
            // Wrong-path data: drop it and refetch from fetch_pc.
            cancel_next = 1'b0;
            state_next  = S_REQ;
          end else begin
            buf_pc_next   = fetch_pc_reg;
            buf_inst_next = inst_sram_rdata;
`ifdef IF_ADEF_EN
            adef_next     = 1'b0;
`endif
            state_next    = S_HOLD;
          end
        end else if (br_taken) begin
          cancel_next = 1'b1;
        end
      end

      S_HOLD: begin
        if (br_taken) begin
          // Branch wins over a simultaneous handshake; ID discards the
          // instruction on br_taken, so the buffer is simply abandoned.
          fetch_pc_next = br_target;
          state_next    = S_REQ;
`ifdef IF_ADEF_EN
          adef_next     = 1'b0;
`endif
        end else if (ID_Allow_in) begin
          fetch_pc_next = buf_pc_reg + 32'd4;
          state_next    = S_REQ;
`ifdef IF_ADEF_EN
          adef_next     = 1'b0;
`endif
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  //
  // Reset is synchronous, so during a reset cycle the registers may still hold
  // pre-reset values; every output is qualified with reset so the port shows
  // the reset view (all zero, address = RESET_PC) for the whole reset cycle.
  // ---------------------------------------------------------------------------
  assign hold_active    = !reset && (state_reg == S_HOLD);
  assign IF_to_ID_Valid = hold_active;
  assign inst_sram_req  = !reset && req_int;
  assign buf_bus        = {buf_pc_reg, buf_inst_reg};

  // The bus reads as zero whenever no instruction is being offered.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi = gi + 1) begin : g_bus_mask
      assign IF_to_ID_Bus[gi] = hold_active & buf_bus[gi];
    end
  endgenerate

  assign addr_src = reset ? RESET_PC : fetch_pc_reg;

`ifdef IF_ADEF_EN
  assign inst_sram_addr = addr_src;
  assign IF_adef        = hold_active & adef_reg;
`else
  assign inst_sram_addr = {addr_src[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Bench for if_fetch_unit. A small SRAM responder (configurable accept policy
// and read latency) and a transaction-level reference model of the fetch
// stream are kept here; directed scenarios are followed by a long randomized
// run. Inputs change on the falling edge, outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_next = 1'b1;
  logic        ID_Allow_in = 1'b0;
  logic [33:0] br_bus = '0;
  logic        IF_to_ID_Valid;
  logic [63:0] IF_to_ID_Bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;
`ifdef IF_ADEF_EN
  logic        IF_adef;
`endif

  int checks = 0;
  int errors = 0;

  // SRAM responder state
  int          sram_k   = 1;   // read latency in cycles, 0 = random 1..4
  int          ack_mode = 1;   // 0 never accept, 1 always, 2 random
  bit          inject_dok = 1'b0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] lat_addr = '0;
  bit          acc_now = 1'b0;
  logic [31:0] acc_addr = '0;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .ID_Allow_in       (ID_Allow_in),
    .br_bus            (br_bus),
    .IF_to_ID_Valid    (IF_to_ID_Valid),
    .IF_to_ID_Bus      (IF_to_ID_Bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
`ifdef IF_ADEF_EN
    ,
    .IF_adef           (IF_adef)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // Set all inputs for the coming rising edge.
  task automatic drive(input logic allow, input logic br, input logic [31:0] tgt);
    ID_Allow_in = allow;
    br_bus      = {br, tgt, 1'($urandom_range(0, 1))};
    acc_now     = inst_sram_req && !busy &&
                  (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 1) == 1));
    acc_addr    = inst_sram_addr;
    inst_sram_addr_ok = acc_now;
    if (inject_dok) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hdead_beef;
    end else if (busy && cnt == 0) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(lat_addr);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = $urandom;
    end
  endtask

  // Advance one clock; the SRAM responder resets together with the DUT.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      busy = 1'b0;
    end else begin
      if (inst_sram_data_ok) busy = 1'b0;
      else if (busy) cnt = cnt - 1;
      if (acc_now) begin
        busy     = 1'b1;
        lat_addr = acc_addr;
        cnt      = ((sram_k == 0) ? int'($urandom_range(1, 4)) : sram_k) - 1;
      end
    end
    #1;
    reset = reset_next;
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge of the first cycle after reset.
  task automatic apply_reset();
    reset_next = 1'b1;
    drive(0, 0, 0); tick();
    drive(0, 0, 0); tick();
    reset_next = 1'b0;
    drive(0, 0, 0); tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (inst_sram_req !== 1'b0 || IF_to_ID_Valid !== 1'b0 || IF_to_ID_Bus !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs got req=%0b valid=%0b bus=%h required 0/0/0",
               inst_sram_req, IF_to_ID_Valid, IF_to_ID_Bus);
    end
    checks++;
    if (inst_sram_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_addr got=%h required=%h", inst_sram_addr, RESET_PC);
    end
`ifdef IF_ADEF_EN
    checks++;
    if (IF_adef !== 1'b0) begin
      errors++;
      $display("FAIL reset_adef got=%0b required=0", IF_adef);
    end
`endif
    apply_reset();
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_req got req=%0b addr=%h required 1/%h",
               inst_sram_req, inst_sram_addr, RESET_PC);
    end
    $display("reset released, first request addr=%h", inst_sram_addr);
  endtask

  task automatic test_sequential();
    logic [31:0] pc_e;
    sram_k = 1; ack_mode = 1;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      pc_e = RESET_PC + 32'(4 * (i / 3));
      checks++;
      if (IF_to_ID_Valid !== ((i % 3) == 2)) begin
        errors++;
        $display("FAIL seq_valid cyc=%0d got=%0b required=%0b", i, IF_to_ID_Valid, (i % 3) == 2);
      end
      if ((i % 3) == 0) begin
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== pc_e) begin
          errors++;
          $display("FAIL seq_req cyc=%0d got req=%0b addr=%h required 1/%h",
                   i, inst_sram_req, inst_sram_addr, pc_e);
        end
      end
      if ((i % 3) == 2) begin
        checks++;
        if (IF_to_ID_Bus !== {pc_e, mem_word(pc_e)}) begin
          errors++;
          $display("FAIL seq_bus cyc=%0d got=%h required=%h", i, IF_to_ID_Bus, {pc_e, mem_word(pc_e)});
        end
        $display("seq deliver pc=%h inst=%h", IF_to_ID_Bus[63:32], IF_to_ID_Bus[31:0]);
      end
      drive(1, 0, 0); tick();
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_bus;
    sram_k = 1; ack_mode = 1;
    apply_reset();
    drive(0, 0, 0); tick();
    drive(0, 0, 0); tick();
    exp_bus = {RESET_PC, mem_word(RESET_PC)};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus !== exp_bus || inst_sram_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got valid=%0b bus=%h req=%0b required 1/%h/0",
                 i, IF_to_ID_Valid, IF_to_ID_Bus, inst_sram_req, exp_bus);
      end
      drive(0, 0, 0); tick();
    end
    drive(1, 0, 0); tick();
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC + 32'd4 || IF_to_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got req=%0b addr=%h valid=%0b required 1/%h/0",
               inst_sram_req, inst_sram_addr, IF_to_ID_Valid, RESET_PC + 32'd4);
    end
    $display("stall released, next request addr=%h", inst_sram_addr);
  endtask

  task automatic test_branch_wait();
    bit seen;
    int cyc;
    sram_k = 4; ack_mode = 1;
    apply_reset();
    drive(1, 0, 0); tick();                  // request accepted
    drive(1, 1, 32'h1c00_0100); tick();      // branch while waiting
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      checks++;
      if (IF_to_ID_Valid !== 1'b0) begin
        errors++;
        $display("FAIL brwait_no_valid cyc=%0d got=%0b required=0", i, IF_to_ID_Valid);
      end
      if (inst_sram_req === 1'b1) begin
        seen = 1'b1;
        cyc  = i;
      end else begin
        drive(1, 0, 0); tick();
      end
    end
    checks++;
    if (!seen || cyc != 3 || inst_sram_addr !== 32'h1c00_0100) begin
      errors++;
      $display("FAIL brwait_refetch got seen=%0b cyc=%0d addr=%h required 1/3/1c000100",
               seen, cyc, inst_sram_addr);
    end
    sram_k = 1;
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus !== {32'h1c00_0100, mem_word(32'h1c00_0100)}) begin
      errors++;
      $display("FAIL brwait_deliver got valid=%0b bus=%h required 1/%h",
               IF_to_ID_Valid, IF_to_ID_Bus, {32'h1c00_0100, mem_word(32'h1c00_0100)});
    end
    $display("branch in WAIT, delivered pc=%h", IF_to_ID_Bus[63:32]);
  endtask

  task automatic test_branch_hold();
    sram_k = 1; ack_mode = 1;
    apply_reset();
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b1) begin
      errors++;
      $display("FAIL brhold_in_hold got=%0b required=1", IF_to_ID_Valid);
    end
    drive(1, 1, 32'h1c00_0200); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b0 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0200) begin
      errors++;
      $display("FAIL brhold_redirect got valid=%0b req=%0b addr=%h required 0/1/1c000200",
               IF_to_ID_Valid, inst_sram_req, inst_sram_addr);
    end
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus !== {32'h1c00_0200, mem_word(32'h1c00_0200)}) begin
      errors++;
      $display("FAIL brhold_deliver got valid=%0b bus=%h required 1/%h",
               IF_to_ID_Valid, IF_to_ID_Bus, {32'h1c00_0200, mem_word(32'h1c00_0200)});
    end
    $display("branch in HOLD, delivered pc=%h", IF_to_ID_Bus[63:32]);
  endtask

  task automatic test_branch_req_accept();
    int reqs;
    sram_k = 1; ack_mode = 1;
    apply_reset();
    drive(1, 1, 32'h1c00_0300); tick();      // accepted together with branch
    checks++;
    if (inst_sram_req !== 1'b0 || IF_to_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL brreq_wait got req=%0b valid=%0b required 0/0", inst_sram_req, IF_to_ID_Valid);
    end
    drive(1, 0, 0); tick();                  // stale data returns
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      if (inst_sram_req === 1'b1) begin
        reqs++;
        checks++;
        if (inst_sram_addr !== 32'h1c00_0300) begin
          errors++;
          $display("FAIL brreq_addr got=%h required=1c000300", inst_sram_addr);
        end
      end
      if (i < 2) begin
        checks++;
        if (IF_to_ID_Valid !== 1'b0) begin
          errors++;
          $display("FAIL brreq_stale_valid cyc=%0d got=%0b required=0", i, IF_to_ID_Valid);
        end
        drive(1, 0, 0); tick();
      end
    end
    checks++;
    if (reqs != 1 || IF_to_ID_Valid !== 1'b1 ||
        IF_to_ID_Bus !== {32'h1c00_0300, mem_word(32'h1c00_0300)}) begin
      errors++;
      $display("FAIL brreq_deliver got reqs=%0d valid=%0b bus=%h required 1/1/%h",
               reqs, IF_to_ID_Valid, IF_to_ID_Bus, {32'h1c00_0300, mem_word(32'h1c00_0300)});
    end
    $display("branch on accept, delivered pc=%h", IF_to_ID_Bus[63:32]);
  endtask

  task automatic test_wrap();
    sram_k = 1; ack_mode = 1;
    apply_reset();
    drive(1, 1, 32'hffff_fffc); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hffff_fffc) begin
      errors++;
      $display("FAIL wrap_req got req=%0b addr=%h required 1/fffffffc", inst_sram_req, inst_sram_addr);
    end
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus[63:32] !== 32'hffff_fffc) begin
      errors++;
      $display("FAIL wrap_deliver got valid=%0b pc=%h required 1/fffffffc",
               IF_to_ID_Valid, IF_to_ID_Bus[63:32]);
    end
    drive(1, 0, 0); tick();
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next got req=%0b addr=%h required 1/00000000", inst_sram_req, inst_sram_addr);
    end
    $display("wrap, next request addr=%h", inst_sram_addr);
  endtask

  task automatic test_protocol_error();
    logic [63:0] exp_bus;
    sram_k = 1; ack_mode = 0;
    apply_reset();
    inject_dok = 1'b1;
    drive(1, 0, 0); tick();
    inject_dok = 1'b0;
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC || IF_to_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL proto_req got req=%0b addr=%h valid=%0b required 1/%h/0",
               inst_sram_req, inst_sram_addr, IF_to_ID_Valid, RESET_PC);
    end
    ack_mode = 1;
    drive(0, 0, 0); tick();
    drive(0, 0, 0); tick();
    exp_bus = {RESET_PC, mem_word(RESET_PC)};
    inject_dok = 1'b1;
    drive(0, 0, 0); tick();
    inject_dok = 1'b0;
    checks++;
    if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus !== exp_bus) begin
      errors++;
      $display("FAIL proto_hold got valid=%0b bus=%h required 1/%h", IF_to_ID_Valid, IF_to_ID_Bus, exp_bus);
    end
    $display("stray data_ok ignored, bus=%h", IF_to_ID_Bus);
  endtask

  task automatic test_reset_mid();
    sram_k = 1; ack_mode = 1;
    apply_reset();
    drive(0, 0, 0); tick();
    drive(0, 0, 0); tick();                  // now holding an instruction
    reset_next = 1'b1;
    drive(0, 0, 0); tick();                  // reset asserted, state not yet reset
    checks++;
    if (IF_to_ID_Valid !== 1'b0 || IF_to_ID_Bus !== 64'h0 || inst_sram_req !== 1'b0 ||
        inst_sram_addr !== RESET_PC) begin
      errors++;
      $display("FAIL midrst_outputs got valid=%0b bus=%h req=%0b addr=%h required 0/0/0/%h",
               IF_to_ID_Valid, IF_to_ID_Bus, inst_sram_req, inst_sram_addr, RESET_PC);
    end
    reset_next = 1'b0;
    drive(0, 0, 0); tick();
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC || IF_to_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_restart got req=%0b addr=%h valid=%0b required 1/%h/0",
               inst_sram_req, inst_sram_addr, IF_to_ID_Valid, RESET_PC);
    end
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus !== {RESET_PC, mem_word(RESET_PC)}) begin
      errors++;
      $display("FAIL midrst_deliver got valid=%0b bus=%h required 1/%h",
               IF_to_ID_Valid, IF_to_ID_Bus, {RESET_PC, mem_word(RESET_PC)});
    end
    $display("reset mid-run, restart pc=%h", IF_to_ID_Bus[63:32]);
  endtask

`ifdef IF_ADEF_EN
  task automatic test_adef();
    sram_k = 1; ack_mode = 0;
    apply_reset();
    drive(1, 1, 32'h1c00_0102); tick();
    checks++;
    if (inst_sram_req !== 1'b0 || IF_to_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL adef_noreq got req=%0b valid=%0b required 0/0", inst_sram_req, IF_to_ID_Valid);
    end
    drive(0, 0, 0); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus !== {32'h1c00_0102, 32'h0} || IF_adef !== 1'b1) begin
      errors++;
      $display("FAIL adef_hold got valid=%0b bus=%h adef=%0b required 1/1c00010200000000/1",
               IF_to_ID_Valid, IF_to_ID_Bus, IF_adef);
    end
    ack_mode = 1;
    drive(0, 1, 32'h1c00_0400); tick();
    checks++;
    if (IF_adef !== 1'b0 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0400) begin
      errors++;
      $display("FAIL adef_clear got adef=%0b req=%0b addr=%h required 0/1/1c000400",
               IF_adef, inst_sram_req, inst_sram_addr);
    end
    $display("address error delivered, then redirect to %h", inst_sram_addr);
  endtask
`else
  task automatic test_addr_align();
    sram_k = 1; ack_mode = 0;
    apply_reset();
    drive(1, 1, 32'h1c00_0102); tick();
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin
      errors++;
      $display("FAIL align_addr got req=%0b addr=%h required 1/1c000100", inst_sram_req, inst_sram_addr);
    end
    ack_mode = 1;
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    checks++;
    if (IF_to_ID_Valid !== 1'b1 || IF_to_ID_Bus !== {32'h1c00_0102, mem_word(32'h1c00_0100)}) begin
      errors++;
      $display("FAIL align_deliver got valid=%0b bus=%h required 1/%h",
               IF_to_ID_Valid, IF_to_ID_Bus, {32'h1c00_0102, mem_word(32'h1c00_0100)});
    end
    $display("aligned fetch for pc=%h", IF_to_ID_Bus[63:32]);
  endtask
`endif

  // Randomized run against a transaction-level model: the stream delivered
  // to ID must be the sequential program from the last redirect, every
  // surviving SRAM return must appear on the bus the next cycle, an offered
  // instruction must stay put until taken, and each handshake/discard/redirect
  // must be followed by a request for the expected PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    bit          fl_good, pend, hold_chk, req_chk;
    logic [31:0] fl_pc, tgt;
    logic [63:0] pend_bus, hold_bus;
    logic        br, allow, v, rq, aok, dok;
    logic [63:0] bus;
    logic [31:0] addr;
    int          delivered;
    sram_k = 0; ack_mode = 2;
    apply_reset();
    exp_pc = RESET_PC; fl_good = 0; pend = 0; hold_chk = 0; req_chk = 1;
    fl_pc = '0; pend_bus = '0; hold_bus = '0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      v = IF_to_ID_Valid; bus = IF_to_ID_Bus; rq = inst_sram_req; addr = inst_sram_addr;
      if (pend) begin
        checks++;
        if (v !== 1'b1 || bus !== pend_bus) begin
          errors++;
          $display("FAIL rnd_deliver cyc=%0d got valid=%0b bus=%h required 1/%h", c, v, bus, pend_bus);
        end
      end
      if (hold_chk) begin
        checks++;
        if (v !== 1'b1 || bus !== hold_bus) begin
          errors++;
          $display("FAIL rnd_hold cyc=%0d got valid=%0b bus=%h required 1/%h", c, v, bus, hold_bus);
        end
      end
      if (req_chk) begin
        checks++;
        if (rq !== 1'b1 || addr !== exp_pc) begin
          errors++;
          $display("FAIL rnd_req cyc=%0d got req=%0b addr=%h required 1/%h", c, rq, addr, exp_pc);
        end
      end
      if (v !== 1'b1) begin
        checks++;
        if (bus !== 64'h0) begin
          errors++;
          $display("FAIL rnd_bus_idle cyc=%0d got=%h required=0", c, bus);
        end
      end
      pend = 0; hold_chk = 0; req_chk = 0;

      br    = ($urandom_range(0, 11) == 0);
      allow = ($urandom_range(0, 2) != 0);
      tgt   = ($urandom_range(0, 15) == 0) ? 32'hffff_fff0 + 32'($urandom_range(0, 3) * 4)
                                           : {16'h1c00, 14'($urandom_range(0, 16383)), 2'b00};
      drive(allow, br, tgt);
      aok = inst_sram_addr_ok; dok = inst_sram_data_ok;

      if (rq && aok) begin
        if (!br) begin
          checks++;
          if (addr !== exp_pc) begin
            errors++;
            $display("FAIL rnd_fetch_addr cyc=%0d got=%h required=%h", c, addr, exp_pc);
          end
        end
        fl_good = 1; fl_pc = addr;
      end
      if (br) fl_good = 0;
      if (dok) begin
        if (fl_good) begin
          pend = 1; pend_bus = {fl_pc, inst_sram_rdata};
        end else begin
          req_chk = 1;
        end
        fl_good = 0;
      end
      if (v) begin
        if (br) begin
          req_chk = 1;
        end else if (allow) begin
          checks++;
          if (bus !== {exp_pc, mem_word(exp_pc)}) begin
            errors++;
            $display("FAIL rnd_handshake cyc=%0d got=%h required=%h", c, bus, {exp_pc, mem_word(exp_pc)});
          end
          $display("rnd deliver pc=%h inst=%h", bus[63:32], bus[31:0]);
          exp_pc = exp_pc + 32'd4;
          req_chk = 1;
          delivered++;
        end else begin
          hold_chk = 1; hold_bus = bus;
        end
      end
      if (br && rq && !aok) req_chk = 1;
      if (br) exp_pc = tgt;
      tick();
    end
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rnd_progress got=%0d deliveries required at least 100", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_hold();
    test_branch_req_accept();
    test_wrap();
    test_protocol_error();
    test_reset_mid();
`ifdef IF_ADEF_EN
    test_adef();
`else
    test_addr_align();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
